share_arb2: RTL

Two-requester round-robin arbiter that sequences a shared single-output datapath. It owns the select line of the team's 2:1 data multiplexer and decides which of two sources drives the shared output. It has per-requester request/release handshakes, a bounded hold time with forced rotation, and an optional dead-cycle turnaround between owners. It sits between the two source controllers and the shared mux/output register.

---
 rtl/share_arb2_pkg.sv | 23 ++
 rtl/share_arb2_if.sv | 11 +
 rtl/share_arb2_sat_cnt4.sv | 23 ++
 rtl/share_arb2.sv | 101 ++++++++++
 4 files changed

// File: rtl/share_arb2_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
package share_arb2_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Owner choice from an unowned point; on a tie the side not granted last wins.
  function automatic state_t pick_owner(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   return OWN0;
      2'b10:   return OWN1;
      2'b11:   return last ? OWN0 : OWN1;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/share_arb2_if.sv
// Request/release/grant bundle between the two sources and the arbiter.
interface share_arb2_if;
  logic [1:0] req;
  logic [1:0] rel;
  logic [1:0] gnt;
  logic       sel;
  logic       valid;

  modport master (output req, output rel, input gnt, input sel, input valid);
  modport slave  (input req, input rel, output gnt, output sel, output valid);
endinterface

// File: rtl/share_arb2_sat_cnt4.sv
// 4-bit up counter with synchronous clear, enable and saturation at 15.
module sat_cnt4
  import share_arb2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  // Clear wins over count; count stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/share_arb2.sv
// Two-requester round-robin arbiter owning the shared 2:1 mux select.
module share_arb2
  import share_arb2_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TURN     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  share_arb2_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(TURN - 1);

  state_t           state;
  state_t           next_state;
  logic             last;
  logic [1:0]       gnt_q;
  logic             sel_q;
  logic             valid_q;
  logic [CNT_W-1:0] hold;
  logic [CNT_W-1:0] gap;
  logic             own;
  logic             leave;
  logic             grant_start;
  logic             gap_start;
  logic             in_own;

  assign in_own    = (state == OWN0) || (state == OWN1);
  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

  sat_cnt4 u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (grant_start),
    .en   (in_own),
    .q    (hold)
  );

  sat_cnt4 u_gap (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (gap_start),
    .en   (state == GAP),
    .q    (gap)
  );

  // Next-state selection plus grant/turnaround start strobes.
  always_comb begin
    next_state  = state;
    gap_start   = 1'b0;
    grant_start = 1'b0;
    leave       = 1'b0;
    own         = (state == OWN1);
    case (state)
      IDLE: next_state = pick_owner(bus.req, last);
      OWN0, OWN1: begin
        leave = bus.rel[own] | ~bus.req[own] | ((hold == HOLD_LAST) & bus.req[~own]);
        if (leave) begin
          if (TURN != 0) begin
            next_state = GAP;
            gap_start  = 1'b1;
          end else begin
            // Direct hand-over: the leaving owner counts as most recent.
            next_state = pick_owner(bus.req, own);
          end
        end
      end
      GAP: begin
        if (gap == GAP_LAST) next_state = pick_owner(bus.req, last);
      end
      default: next_state = IDLE;
    endcase
    // A re-grant to the same side after a zero-turn exit is still a new grant.
    grant_start = ((next_state == OWN0) || (next_state == OWN1)) &&
                  ((state == IDLE) || (state == GAP) || leave);
  end

  // State, last-owner and registered outputs; sel only moves when a grant begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      gnt_q   <= {next_state == OWN1, next_state == OWN0};
      valid_q <= (next_state == OWN0) || (next_state == OWN1);
      if (grant_start) begin
        last  <= (next_state == OWN1);
        sel_q <= (next_state == OWN1);
      end
    end
  end

endmodule
